// File: rtl/cb_read_sequencer_pkg.sv
// cb_read_sequencer_pkg: shared FSM state type and circular-buffer geometry.
package cb_read_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} cb_state_t;
  localparam int CB_AW = 11;
  localparam int CB_DW = 144;
  localparam int CB_SAMPLE_W = 18;
  localparam int CB_RD_LAT = 1;
endpackage

// File: rtl/cb_valid_pipe.sv
// cb_valid_pipe: DEPTH-stage shift register aligning sweep tags with buffer read data.
module cb_valid_pipe #(
  parameter int DEPTH = 1,
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge clock)
    if (reset) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/cb_read_sequencer.sv
// cb_read_sequencer: sweeps relative buffer addresses 0..N-1 and streams the read words.
// Optional sticky overrun output when CB_READ_SEQ_OVERRUN_EN is defined.
module cb_read_sequencer
  import cb_read_sequencer_pkg::*;
#(
  parameter int AW = CB_AW,
  parameter int DW = CB_DW,
  parameter int RD_LAT = CB_RD_LAT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   nwords,
  input  logic          wen_mon,
  output logic [AW-1:0] cb_addr,
  input  logic [DW-1:0] cb_data,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          dout_first,
  output logic          dout_last,
  output logic [AW-1:0] word_idx,
  output logic          busy,
  output logic          done
`ifdef CB_READ_SEQ_OVERRUN_EN
  , output logic        overrun
`endif
);
  localparam int DCW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [AW:0] NMAX = {1'b1, {AW{1'b0}}};
  cb_state_t state;
  logic [AW:0] addr, n, n_req;
  logic [DCW-1:0] dcnt;
  logic zdone, accept, drain_end;
  logic [AW+2:0] p_in, p_out;
  assign n_req = nwords > NMAX ? NMAX : nwords;
  assign drain_end = state == DRAIN && dcnt == DCW'(RD_LAT - 1);
  // The drain's final cycle carries done, so a new sweep may start right there.
  assign accept = start && (state == IDLE || drain_end);
  assign p_in = state == SWEEP ? {1'b1, addr == '0, addr == n - 1'b1, addr[AW-1:0]} : '0;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      n <= '0;
      dcnt <= '0;
      zdone <= 1'b0;
    end else begin
      zdone <= accept && n_req == '0;
      if (accept && n_req != '0) begin
        state <= SWEEP;
        n <= n_req;
        addr <= '0;
      end else if (state == SWEEP) begin
        if (addr == n - 1'b1) begin
          state <= DRAIN;
          addr <= '0;
          dcnt <= '0;
        end else addr <= addr + 1'b1;
      end else if (state == DRAIN) begin
        if (drain_end) state <= IDLE;
        else dcnt <= dcnt + 1'b1;
      end
    end
  cb_valid_pipe #(.DEPTH(RD_LAT), .W(AW + 3)) u_pipe (
    .clock(clock),
    .reset(reset),
    .d(p_in),
    .q(p_out)
  );
  assign cb_addr = addr[AW-1:0];
  assign busy = state != IDLE;
  assign dout_valid = p_out[AW+2];
  assign dout_first = p_out[AW+1];
  assign dout_last = p_out[AW];
  assign word_idx = p_out[AW-1:0];
  assign dout = dout_valid ? cb_data : '0;
  assign done = dout_last | zdone;
`ifdef CB_READ_SEQ_OVERRUN_EN
  always_ff @(posedge clock)
    if (reset) overrun <= 1'b0;
    else if (busy && (wen_mon || (start && !accept))) overrun <= 1'b1;
`else
  logic unused_wen_mon;
  assign unused_wen_mon = wen_mon;
`endif
endmodule

// File: tb/tb_cb_read_sequencer.sv
// tb_cb_read_sequencer: directed and randomized sweeps checked against a sample-level buffer model.
module tb_cb_read_sequencer;
  import cb_read_sequencer_pkg::*;
  logic clock = 1'b0, reset, start, wen_mon;
  logic [CB_AW:0] nwords;
  logic [CB_AW-1:0] cb_addr, word_idx;
  logic [CB_DW-1:0] cb_data, dout, first_word, w57;
  logic dout_valid, dout_first, dout_last, busy, done;
`ifdef CB_READ_SEQ_OVERRUN_EN
  logic overrun;
`endif
  int tests = 0, fails = 0, tot;
  logic [CB_SAMPLE_W-1:0] samp [16384];

  cb_read_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .nwords(nwords), .wen_mon(wen_mon),
    .cb_addr(cb_addr), .cb_data(cb_data), .dout(dout), .dout_valid(dout_valid),
    .dout_first(dout_first), .dout_last(dout_last), .word_idx(word_idx),
    .busy(busy), .done(done)
`ifdef CB_READ_SEQ_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  always #5 clock = ~clock;

  // Word at relative address a holds the 8 samples ending 8*a before the newest, oldest in the MSBs.
  function automatic logic [CB_DW-1:0] bword(int a);
    logic [CB_DW-1:0] w = '0;
    for (int j = 0; j < 8; j++) w = {w[CB_DW-CB_SAMPLE_W-1:0], samp[(tot - 8*a - 8 + j) & 16383]};
    return w;
  endfunction

  always @(posedge clock) cb_data <= bword(int'(cb_addr));

  task automatic chk(input string tag, input logic [CB_DW-1:0] obs, input logic [CB_DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".cb_addr"}, cb_addr, 0);
    chk({tag, ".dout_valid"}, dout_valid, 0);
    chk({tag, ".dout"}, dout, 0);
    chk({tag, ".word_idx"}, word_idx, 0);
    chk({tag, ".first"}, dout_first, 0);
    chk({tag, ".last"}, dout_last, 0);
    chk({tag, ".done"}, done, 0);
  endtask

  task automatic write_word();
    for (int j = 0; j < 8; j++) begin
      samp[tot & 16383] = CB_SAMPLE_W'($urandom);
      tot++;
    end
    wen_mon = 1;
    @(negedge clock);
    wen_mon = 0;
  endtask

  // One sweep, checked every cycle from t+1; optionally chains a start into the done cycle,
  // pokes start/wen_mon mid-sweep, or asserts reset in cycle t+abort_c.
  task automatic sweep(input int nw, input bit pre, input int chain, input bit poke, input int abort_c);
    int n, lim, nv;
    n = nw > 2048 ? 2048 : nw;
    lim = n > 0 ? n + 1 : 1;
    nv = 0;
    first_word = '0;
    if (!pre) begin
      nwords = (CB_AW + 1)'(nw);
      start = 1;
    end
    @(negedge clock);
    start = 0;
    for (int c = 1; c <= lim; c++) begin
      bit v;
      int k;
      v = n > 0 && c >= 2;
      k = v ? c - 2 : 0;
      chk("busy", busy, n > 0);
      chk("cb_addr", cb_addr, (n > 0 && c <= n) ? c - 1 : 0);
      chk("dout_valid", dout_valid, v);
      chk("word_idx", word_idx, v ? k : 0);
      chk("dout", dout, v ? bword(k) : '0);
      chk("dout_first", dout_first, v && k == 0);
      chk("dout_last", dout_last, v && k == n - 1);
      chk("done", done, c == lim);
      nv += int'(dout_valid);
      if (dout_first) first_word = dout;
      start = 0;
      wen_mon = 0;
      if (poke && c == 2) begin
        start = 1;
        nwords = 5;
        wen_mon = 1;
      end
      if (c == abort_c) begin
        reset = 1;
        @(negedge clock);
        reset = 0;
        idle_chk("abort");
        repeat (4) begin
          @(negedge clock);
          idle_chk("post_abort");
        end
        return;
      end
      if (c == lim && chain >= 0) begin
        nwords = (CB_AW + 1)'(chain);
        start = 1;
      end
      if (c < lim) @(negedge clock);
    end
    chk("nvalid", nv, n);
    if (chain < 0) begin
      @(negedge clock);
      idle_chk("after");
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tot = 64;
    for (int i = 0; i < 16384; i++) samp[i] = i < 64 ? CB_SAMPLE_W'(i + 1) : CB_SAMPLE_W'($urandom);
    w57 = '0;
    for (int j = 0; j < 8; j++) w57 = {w57[CB_DW-CB_SAMPLE_W-1:0], CB_SAMPLE_W'(57 + j)};
    reset = 1;
    start = 0;
    nwords = '0;
    wen_mon = 0;
    repeat (3) @(negedge clock);
    idle_chk("reset");
`ifdef CB_READ_SEQ_OVERRUN_EN
    chk("overrun_reset", overrun, 0);
`endif
    reset = 0;
    @(negedge clock);
    sweep(4, 0, -1, 0, 0);
    chk("word0", first_word, w57);
    sweep(1, 0, -1, 0, 0);
    sweep(0, 0, -1, 0, 0);
    sweep(2048, 0, -1, 0, 0);
    sweep(4095, 0, -1, 0, 0);
    sweep(10, 0, -1, 1, 0);
`ifdef CB_READ_SEQ_OVERRUN_EN
    chk("overrun_set", overrun, 1);
`endif
    sweep(3, 0, 6, 0, 0);
    sweep(6, 1, 0, 0, 0);
    sweep(0, 1, 2, 0, 0);
    sweep(2, 1, -1, 0, 0);
`ifdef CB_READ_SEQ_OVERRUN_EN
    chk("overrun_sticky", overrun, 1);
`endif
    sweep(8, 0, -1, 0, 4);
`ifdef CB_READ_SEQ_OVERRUN_EN
    chk("overrun_cleared", overrun, 0);
`endif
    sweep(4, 0, -1, 0, 0);
    repeat (10) begin
      int nw, c2;
      if ($urandom_range(0, 1) == 1) write_word();
      nw = int'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) begin
        c2 = int'($urandom_range(0, 20));
        sweep(nw, 0, c2, 0, 0);
        sweep(c2, 1, -1, 0, 0);
      end else sweep(nw, 0, -1, 0, 0);
    end
`ifdef CB_READ_SEQ_OVERRUN_EN
    chk("overrun_idle_writes", overrun, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
